// File: rtl/lif_neuron_array.sv
// Array of leaky integrate-and-fire neurons sharing one weight memory.
// Pre-synaptic events add a weight row to every potential; at the end of a
// timestep the array drains the last event, leaks, then fires.
module lif_neuron_array #(
    parameter int NUM_NEURONS = 32,
    parameter int PRE_SIZE    = 32,
    parameter int W_WIDTH     = 8,
    parameter int V_WIDTH     = 16,
    parameter int THRESHOLD   = 64,
    parameter int LEAK_SHIFT  = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en_accum,
    input  logic                      en_activ,
    input  logic                      spk_valid,
    input  logic [4:0]                spk_addr,
    output logic                      spk_ready,
    input  logic                      w_wr_en,
    input  logic [9:0]                w_wr_addr,
    input  logic signed [W_WIDTH-1:0] w_wr_data,
    output logic [31:0]               post_synpt_spk,
    output logic                      spk_out_valid,
    output logic                      busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACCUM = 3'd1,
        S_DRAIN = 3'd2,
        S_LEAK  = 3'd3,
        S_FIRE  = 3'd4
    } state_t;

    localparam logic signed [V_WIDTH-1:0] V_TH  = V_WIDTH'(THRESHOLD);
    localparam logic signed [V_WIDTH-1:0] V_MAX = {1'b0, {(V_WIDTH-1){1'b1}}};
    localparam logic signed [V_WIDTH-1:0] V_MIN = {1'b1, {(V_WIDTH-1){1'b0}}};

    state_t                      r_state;
    state_t                      w_next;
    logic                        r_evt_vld_p0;
    logic [4:0]                  r_evt_addr_p0;
    logic signed [W_WIDTH-1:0]   r_w [PRE_SIZE][NUM_NEURONS];
    logic signed [V_WIDTH-1:0]   r_v [NUM_NEURONS];
    logic [31:0]                 r_post_spk;
    logic                        r_out_vld;
    logic [31:0]                 w_fire;

    // Saturating add of a sign-extended weight to a potential.
    function automatic logic signed [V_WIDTH-1:0] sat_add(
        input logic signed [V_WIDTH-1:0] v,
        input logic signed [W_WIDTH-1:0] w
    );
        logic signed [V_WIDTH:0] s;
        s = {v[V_WIDTH-1], v} + {{(V_WIDTH+1-W_WIDTH){w[W_WIDTH-1]}}, w};
        if (s[V_WIDTH] != s[V_WIDTH-1])
            return s[V_WIDTH] ? V_MIN : V_MAX;
        return s[V_WIDTH-1:0];
    endfunction

    // Leak toward zero; magnitude only shrinks, so no overflow is possible.
    function automatic logic signed [V_WIDTH-1:0] leak(
        input logic signed [V_WIDTH-1:0] v
    );
        return v - (v >>> LEAK_SHIFT);
    endfunction

    assign spk_ready      = !rst && (r_state == S_ACCUM);
    assign busy           = !rst && ((r_state == S_DRAIN) || (r_state == S_LEAK) ||
                                     (r_state == S_FIRE));
    assign post_synpt_spk = r_post_spk;
    assign spk_out_valid  = r_out_vld;

    // Timestep state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode; end of timestep outranks continued accumulation.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (en_activ)      w_next = S_DRAIN;
                else if (en_accum) w_next = S_ACCUM;
            end
            S_ACCUM: begin
                if (en_activ)       w_next = S_DRAIN;
                else if (!en_accum) w_next = S_IDLE;
            end
            S_DRAIN: w_next = S_LEAK;
            S_LEAK:  w_next = S_FIRE;
            S_FIRE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Stage 0: capture an accepted pre-synaptic event.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_evt_vld_p0  <= 1'b0;
            r_evt_addr_p0 <= '0;
        end else begin
            r_evt_vld_p0 <= spk_ready && spk_valid;
            if (spk_ready && spk_valid) r_evt_addr_p0 <= spk_addr;
        end
    end

    // Weight memory: writable only while idle, never cleared.
    always_ff @(posedge clk) begin
        if (w_wr_en && (r_state == S_IDLE))
            r_w[w_wr_addr[9:5]][w_wr_addr[4:0]] <= w_wr_data;
    end

    // Threshold compare on current potentials.
    always_comb begin
        w_fire = '0;
        for (int n = 0; n < NUM_NEURONS; n++)
            w_fire[n] = (r_v[n] >= V_TH);
    end

    // Stage 1: potentials integrate the registered event, leak, or fire.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < NUM_NEURONS; n++) r_v[n] <= '0;
        end else begin
            for (int n = 0; n < NUM_NEURONS; n++) begin
                case (r_state)
                    S_LEAK:  r_v[n] <= leak(r_v[n]);
                    S_FIRE:  if (w_fire[n]) r_v[n] <= '0;
                    default: if (r_evt_vld_p0)
                                 r_v[n] <= sat_add(r_v[n], r_w[r_evt_addr_p0][n]);
                endcase
            end
        end
    end

    // Fired-neuron vector, updated and flagged only at the fire edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_post_spk <= '0;
            r_out_vld  <= 1'b0;
        end else begin
            r_out_vld <= (r_state == S_FIRE);
            if (r_state == S_FIRE) r_post_spk <= w_fire;
        end
    end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Scoreboard bench for lif_neuron_array against an arithmetic neuron model.
module tb_lif_neuron_array;

    localparam int TH   = 64;
    localparam int LDIV = 8;
    localparam int VMAX = 32767;
    localparam int VMIN = -32768;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en_accum = 1'b0;
    logic              en_activ = 1'b0;
    logic              spk_valid = 1'b0;
    logic [4:0]        spk_addr = '0;
    logic              spk_ready;
    logic              w_wr_en = 1'b0;
    logic [9:0]        w_wr_addr = '0;
    logic signed [7:0] w_wr_data = '0;
    logic [31:0]       post_synpt_spk;
    logic              spk_out_valid;
    logic              busy;

    lif_neuron_array dut (
        .clk(clk), .rst(rst), .en_accum(en_accum), .en_activ(en_activ),
        .spk_valid(spk_valid), .spk_addr(spk_addr), .spk_ready(spk_ready),
        .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
        .post_synpt_spk(post_synpt_spk), .spk_out_valid(spk_out_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] vec;
        int          at;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] exp_hold = '0;
    bit          mon_en = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          mv[32];
    int          mw[32][32];
    int          ev_q[$];
    bit          gaps = 1'b0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Reference model: integer potentials, clamp, floor-divide leak.
    function automatic int clampv(input int x);
        if (x > VMAX) return VMAX;
        if (x < VMIN) return VMIN;
        return x;
    endfunction

    function automatic int floor_div(input int x, input int d);
        if (x >= 0) return x / d;
        return -((-x + d - 1) / d);
    endfunction

    function automatic void model_event(input int a);
        for (int n = 0; n < 32; n++) mv[n] = clampv(mv[n] + mw[a][n]);
    endfunction

    function automatic logic [31:0] model_activ();
        logic [31:0] vec;
        vec = '0;
        for (int n = 0; n < 32; n++) begin
            mv[n] = mv[n] - floor_div(mv[n], LDIV);
            if (mv[n] >= TH) begin
                vec[n] = 1'b1;
                mv[n]  = 0;
            end
        end
        return vec;
    endfunction

    function automatic void model_reset();
        for (int n = 0; n < 32; n++) mv[n] = 0;
        exp_q.delete();
        exp_hold = '0;
    endfunction

    // Monitor: pops the scoreboard on every output pulse, else checks hold.
    always @(negedge clk) begin
        if (mon_en) begin
            if (spk_out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_valid: got vec %0h with nothing expected (cycle %0d)",
                             post_synpt_spk, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("fire_vec", post_synpt_spk, mon_e.vec);
                    check("fire_cycle", cyc, mon_e.at);
                    exp_hold = mon_e.vec;
                end
            end else begin
                check("hold_vec", post_synpt_spk, exp_hold);
            end
        end
    end

    task automatic do_reset(input int ncyc);
        @(negedge clk);
        rst = 1'b1; en_accum = 1'b1; spk_valid = 1'b1; spk_addr = 5'd5;
        repeat (ncyc) @(posedge clk);
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0; en_accum = 1'b0; spk_valid = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_ready", spk_ready, 0);
        check("rst_out_valid", spk_out_valid, 0);
        check("rst_vec", post_synpt_spk, 0);
    endtask

    task automatic wr_w(input int pre, input int post, input int val);
        @(negedge clk);
        w_wr_en = 1'b1; w_wr_addr = {5'(pre), 5'(post)}; w_wr_data = 8'(val);
        mw[pre][post] = val;
        @(negedge clk);
        w_wr_en = 1'b0;
    endtask

    task automatic timestep(input bit coinc, input bit bad_wr, input bit split,
                            input bit rst_leak);
        int          n;
        bit          eff_coinc;
        int          t0;
        exp_t        e;
        n = ev_q.size();
        eff_coinc = coinc && !split && (n > 0);
        if (n > 0 || bad_wr) begin
            @(negedge clk);
            en_accum  = 1'b1;
            spk_valid = 1'($urandom_range(0, 1));
            spk_addr  = 5'($urandom_range(0, 31));
            @(negedge clk);
            spk_valid = 1'b0;
            check("ready_accum", spk_ready, 1);
            check("busy_accum", busy, 0);
            if (bad_wr) begin
                w_wr_en = 1'b1; w_wr_addr = {5'd5, 5'd0}; w_wr_data = -8'sd100;
                @(negedge clk);
                w_wr_en = 1'b0;
            end
            for (int i = 0; i < n - (eff_coinc ? 1 : 0); i++) begin
                spk_valid = 1'b1; spk_addr = 5'(ev_q[i]);
                model_event(ev_q[i]);
                @(negedge clk);
                spk_valid = 1'b0;
                if (gaps) repeat ($urandom_range(0, 1)) @(negedge clk);
            end
            if (split) begin
                en_accum = 1'b0;
                @(negedge clk);
                check("ready_after_drop", spk_ready, 0);
            end
        end else begin
            @(negedge clk);
        end
        en_activ = 1'b1;
        if (eff_coinc) begin
            spk_valid = 1'b1; spk_addr = 5'(ev_q[n-1]);
            model_event(ev_q[n-1]);
        end
        t0 = cyc;
        @(negedge clk);
        en_activ = 1'b0; en_accum = 1'b0; spk_valid = 1'($urandom_range(0, 1));
        check("busy_drain", busy, 1);
        check("ready_drain", spk_ready, 0);
        @(negedge clk);
        spk_valid = 1'b0;
        check("busy_leak", busy, 1);
        if (rst_leak) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            model_reset();
            @(negedge clk);
            rst = 1'b0;
            check("midrst_busy", busy, 0);
            check("midrst_out_valid", spk_out_valid, 0);
        end else begin
            e.vec = model_activ();
            e.at  = t0 + 4;
            exp_q.push_back(e);
            @(negedge clk);
            check("busy_fire", busy, 1);
            @(negedge clk);
            check("busy_idle", busy, 0);
            check("ready_idle", spk_ready, 0);
        end
        ev_q.delete();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(2);
        mon_en = 1'b1;
        for (int p = 0; p < 32; p++) begin
            for (int q = 0; q < 32; q++) begin
                @(negedge clk);
                w_wr_en = 1'b1; w_wr_addr = {5'(p), 5'(q)}; w_wr_data = '0;
                mw[p][q] = 0;
            end
        end
        @(negedge clk);
        w_wr_en = 1'b0;

        // Stray event during reset must not accumulate: one event gives 35, no fire.
        wr_w(5, 0, 40);
        do_reset(2);
        ev_q = '{5};
        timestep(0, 0, 0, 0);

        // Single-timestep fire: 80 -> 70 -> bit0, then v0 = 0.
        do_reset(2);
        ev_q = '{5, 5};
        timestep(0, 0, 0, 0);
        timestep(0, 0, 0, 0);

        // Carry-over: 40 -> 35, then 75 -> 66 fires.
        ev_q = '{5};
        timestep(0, 0, 0, 0);
        ev_q = '{5};
        timestep(0, 0, 0, 0);

        // Weight write during ACCUM is ignored.
        ev_q = '{5, 5};
        timestep(0, 1, 0, 0);

        // Event coincident with en_activ is included.
        ev_q = '{5, 5};
        timestep(1, 0, 0, 0);

        // Reset during LEAK, then a fresh timestep.
        ev_q = '{5, 5};
        timestep(0, 0, 0, 1);
        ev_q = '{5};
        timestep(0, 0, 0, 0);

        // Saturation in both directions.
        wr_w(1, 3, -128);
        for (int i = 0; i < 300; i++) ev_q.push_back(1);
        timestep(0, 0, 0, 0);
        wr_w(2, 4, 127);
        for (int i = 0; i < 300; i++) ev_q.push_back(2);
        timestep(0, 0, 0, 0);

        // Randomized timesteps.
        gaps = 1'b1;
        for (int t = 0; t < 25; t++) begin
            int k;
            bit sp;
            repeat ($urandom_range(0, 3))
                wr_w(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                     int'($urandom_range(0, 255)) - 128);
            k = int'($urandom_range(0, 10));
            for (int i = 0; i < k; i++) ev_q.push_back(int'($urandom_range(0, 31)));
            sp = ($urandom_range(0, 3) == 0);
            timestep(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), sp,
                     ($urandom_range(0, 9) == 0));
        end

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lif_neuron_array.md
LIF_NEURON_ARRAY -- requirements
Module: lif_neuron_array

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 32, meaning post-synaptic neurons in the array.
REQ-002 SHALL have parameter PRE_SIZE, default 32, meaning pre-synaptic inputs (spike address range).
REQ-003 SHALL have parameter W_WIDTH, default 8, meaning signed weight width.
REQ-004 SHALL have parameter V_WIDTH, default 16, meaning signed membrane-potential width.
REQ-005 SHALL have parameter THRESHOLD, default 64, meaning signed firing threshold.
REQ-006 SHALL have parameter LEAK_SHIFT, default 3, meaning leak divisor exponent.
REQ-007 SHALL have port clk, input, 1, meaning the single clock; all logic on rising edge.
REQ-008 SHALL have port rst, input, 1, meaning the reset: synchronous, active-high.
REQ-009 SHALL have port en_accum, input, 1, meaning the accumulate phase is open (from event control).
REQ-010 SHALL have port en_activ, input, 1, meaning end of timestep: leak and fire.
REQ-011 SHALL have port spk_valid, input, 1, meaning spk_addr carries a pre-synaptic event.
REQ-012 SHALL have port spk_addr, input, 5, meaning pre-synaptic index of the event.
REQ-013 SHALL have port spk_ready, output, 1, meaning an event is accepted this cycle.
REQ-014 SHALL have port w_wr_en, input, 1, meaning write one weight.
REQ-015 SHALL have port w_wr_addr, input, 10, meaning {pre[4:0], post[4:0]}.
REQ-016 SHALL have port w_wr_data, input, W_WIDTH, meaning signed weight.
REQ-017 SHALL have port post_synpt_spk, output, 32, meaning the fired-neuron vector, bit n = neuron n.
REQ-018 SHALL have port spk_out_valid, output, 1, meaning a one-cycle pulse when post_synpt_spk is updated.
REQ-019 SHALL have port busy, output, 1, meaning the array is in DRAIN, LEAK or FIRE.

Function
REQ-020 SHALL implement FSM states IDLE, ACCUM, DRAIN, LEAK and FIRE.
REQ-021 SHALL make the following transitions:
- IDLE->ACCUM when en_accum=1 and en_activ=0.
- IDLE->DRAIN when en_activ=1 (empty timestep).
- ACCUM->DRAIN when en_activ=1; en_activ has priority over en_accum.
- ACCUM->IDLE when en_accum=0 and en_activ=0.
- DRAIN->LEAK->FIRE->IDLE, one cycle each, unconditional.
REQ-022 SHALL drive spk_ready=1 only in ACCUM; an event with spk_valid=1 in that state, including the cycle en_activ is sampled, SHALL be accepted.
REQ-023 SHALL register an accepted event at the accepting edge, then add row W[spk_addr][0..31] to all potentials at the next edge (latency 1; one event per cycle sustained).
REQ-024 SHALL sign-extend weights and perform additions saturating to [-2^(V_WIDTH-1), 2^(V_WIDTH-1)-1].
REQ-025 SHALL make LEAK apply v = v - (v >>> LEAK_SHIFT) (arithmetic shift) to every neuron in one cycle, with no saturation needed.
REQ-026 SHALL make FIRE apply the following per neuron n:
- if v[n] >= THRESHOLD: post_synpt_spk[n]=1 and v[n]=0.
- else: post_synpt_spk[n]=0 and v[n] held.
REQ-027 SHALL register post_synpt_spk and assert spk_out_valid for exactly one cycle at the FIRE edge, i.e. the 3rd rising edge after the edge that sampled en_activ.
REQ-028 SHALL hold post_synpt_spk stable until the next FIRE.
REQ-029 SHALL make a weight write take effect only in IDLE and ignore it in all other states.
REQ-030 SHALL implement the weight memory as a PRE_SIZE x NUM_NEURONS register array with no reset; contents persist across timesteps and resets.
REQ-031 SHALL ignore spk_valid outside ACCUM (no event captured).
REQ-032 SHALL carry potentials across timesteps (only leak and fire modify them).

Reset
REQ-033 SHALL, while rst=1, force the following at each edge:
- state=IDLE.
- all potentials=0.
- event pipeline register cleared.
- post_synpt_spk=0.
- spk_out_valid=0.
- spk_ready=0.
- busy=0.
REQ-034 SHALL make reset mid-operation (any state) discard the in-flight event and any pending fire, with no spk_out_valid pulse.

Verification
REQ-035 SHALL cover the following reset check: assert rst 2 cycles -> all outputs 0 and state IDLE; stray spk_valid during rst is not accumulated.
REQ-036 SHALL cover the following single-timestep fire: W[5][0]=40; en_accum; two events addr 5; en_activ -> v0: 80, leak to 70, fire; post_synpt_spk=32'h0000_0001 with spk_out_valid 3 edges after en_activ; v0=0 afterwards.
REQ-037 SHALL cover the following carry-over: W[5][0]=40; one event and activ -> v0 40 leaks to 35, output 0; next timestep one event -> 75 leaks to 66 -> bit0 fires.
REQ-038 SHALL cover the following saturation: W[1][3]=-128; 300 events addr 1 -> v3 clamps at -32768; activ -> leak to -28672, bit3=0; separately W[2][4]=127, 300 events -> 32767, bit4 fires.
REQ-039 SHALL cover the following boundaries:
- w_wr_en during ACCUM is ignored (later spike uses old weight).
- en_activ in IDLE with no events -> post_synpt_spk=0, spk_out_valid pulse after 3 edges.
- event coincident with en_activ is included.
REQ-040 SHALL cover the following reset mid-operation: rst during LEAK -> no spk_out_valid; potentials 0; a subsequent timestep behaves as after a fresh reset.
